// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frames_sent
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT_DATA,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [1:0]              wd_cnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    tx_next;
    logic                    baud_last;
    logic                    timed;
`ifdef UART_TX_PARITY_EN
    logic                    parity_bit;
`endif

    assign baud_last = (baud_cnt == BAUD_MAX);
`ifdef UART_TX_PARITY_EN
    assign timed = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
`else
    assign timed = (state == START) || (state == DATA) || (state == STOP);
`endif

    always_comb begin
        state_next = state;
        shift_next = shift;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) state_next = POP;
            end
            POP: state_next = WAIT_DATA;
            WAIT_DATA: begin
                // Watchdog: give up after four cycles without a valid word
                if (fifo_data_valid) begin
                    shift_next = fifo_data;
                    state_next = START;
                end else if (wd_cnt == 2'd3) begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (baud_last) state_next = DATA;
            end
            DATA: begin
                if (baud_last) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) state_next = STOP;
            end
`endif
            STOP: begin
                if (baud_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the next state so it lines up with the state register
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            wd_cnt      <= 2'd0;
            shift       <= '0;
            tx          <= 1'b1;
            fifo_pop    <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= 16'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            tx       <= tx_next;
            fifo_pop <= (state_next == POP);
            busy     <= (state_next != IDLE);

            if (!timed || baud_last || (state_next != state)) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            wd_cnt <= (state == WAIT_DATA) ? wd_cnt + 2'd1 : 2'd0;

            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (baud_last) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if ((state == STOP) && baud_last) begin
                frames_sent <= frames_sent + 16'd1;
            end
`ifdef UART_TX_PARITY_EN
            if ((state == WAIT_DATA) && fifo_data_valid) begin
                parity_bit <= ^fifo_data;
            end
`endif
        end
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the byte FIFO in the LFSR-to-FIFO data path. Pops one word at a time when the FIFO is non-empty and serializes it onto a UART TX line: start bit, DATA_WIDTH data bits LSB first, one stop bit, at a fixed clocks-per-bit rate. Drives the board's UART TX pin so LFSR output can be captured on a host terminal.

Parameters:
DATA_WIDTH, 8, width of FIFO word and number of serialized data bits (1..16).
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  permits starting a new frame; does not abort a frame in progress.
fifo_empty  input  1  FIFO empty flag.
fifo_pop  output  1  one-cycle pop strobe to FIFO.
fifo_data  input  DATA_WIDTH  FIFO read data.
fifo_data_valid  input  1  qualifies fifo_data; expected 1 cycle after fifo_pop.
tx  output  1  UART serial out, idle high.
busy  output  1  high from pop until end of stop bit.
frames_sent  output  16  count of completed frames, wraps 0xFFFF -> 0x0000.

Behaviour:
- One clock (clk); reset is synchronous and active-high (port reset). Reset sampled at clk edge; dominates all other inputs.
- Reset values: tx=1, fifo_pop=0, busy=0, frames_sent=0, state=IDLE, bit/baud counters=0.
- States: IDLE, POP, WAIT_DATA, START, DATA, STOP.
- IDLE: if enable && !fifo_empty -> POP. Else stay; tx=1.
- POP: fifo_pop=1 for exactly this cycle; busy=1; -> WAIT_DATA.
- WAIT_DATA: when fifo_data_valid=1, latch fifo_data into shift register, -> START. Data ignored when valid=0. Watchdog: if valid not seen within 4 cycles, -> IDLE without transmitting, frames_sent unchanged (guards against spurious empty deassertion).
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0]; each bit held CLKS_PER_BIT cycles; shift right after each bit; after DATA_WIDTH bits -> STOP (or PARITY, see feature).
- STOP: tx=1 for CLKS_PER_BIT cycles; on last cycle frames_sent += 1 (mod 2^16), -> IDLE. busy=0 in IDLE.
- Frame length: (1 + DATA_WIDTH + 1) * CLKS_PER_BIT cycles from first START cycle to end of STOP. Back-to-back: with FIFO non-empty and enable held, next START begins 3 cycles after STOP ends (IDLE, POP, WAIT_DATA with 1-cycle valid latency).
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, reset to 0 on every state entry.
- enable deasserted mid-frame: frame completes; no new pop afterwards.
- fifo_empty asserted while in POP/WAIT_DATA: ignored (pop already issued).
- fifo_pop never asserted when fifo_empty=1 in the same cycle's IDLE decision.
- Reset mid-frame: tx returns to 1 next cycle, frame abandoned, popped word lost, frames_sent cleared.
- tx is a registered output (no glitches).

Optional Feature:
Macro UART_TX_PARITY_EN. Defined: extra PARITY state between DATA and STOP; tx = even parity (XOR of the DATA_WIDTH data bits) for CLKS_PER_BIT cycles; frame length becomes (DATA_WIDTH + 3) * CLKS_PER_BIT. Undefined: no parity state or parity logic; DATA goes directly to STOP.

Test Plan:
- CLKS_PER_BIT=4, reset held 3 cycles with fifo_empty=0 -> tx=1, fifo_pop=0, busy=0, frames_sent=0 throughout reset.
- enable=1, FIFO holds 0xA5, valid 1 cycle after pop -> tx: 0 for 4 clks, then bits 1,0,1,0,0,1,0,1 each 4 clks, then 1 for 4 clks; frames_sent=1; busy drops after stop.
- FIFO holds 0x01,0xFF,0x00, enable held -> three frames, exactly 3 idle-high cycles between each stop end and next start; frames_sent=3; exactly 3 pop strobes.
- fifo_empty=0 but fifo_data_valid never asserted -> single pop, return to IDLE after 4 WAIT_DATA cycles, tx stays 1, frames_sent unchanged.
- Reset asserted during bit 3 of 0x5A -> tx=1 next cycle, state IDLE, frames_sent=0; after release next FIFO word transmits normally.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 between data and stop; send 0x03 -> parity bit=0; frame 44 clks at CLKS_PER_BIT=4.
